// File: rtl/onion_capture_if.sv
// onion_capture_if
//   Control and result bundle of the onion_capture input-capture block.
//   The consumer (register file, loopback checker or testbench) uses the
//   master modport; the capture block uses the slave modport.
//
//   Parameter:
//     WIDTH      result width in bits (must match the attached onion_capture)
//   Signals:
//     arm        one-cycle pulse starting a measurement
//     mode       0 = period (rise to rise), 1 = high width (rise to fall)
//     disarm     abort a pending or running measurement
//     ack        consumer acknowledge of a held result
//     result_o   measured cycle count, stable while valid_o is high
//     valid_o    result_o holds a completed measurement
//     overflow_o measurement saturated, qualified by valid_o
//     busy_o     waiting for the start edge or measuring
interface onion_capture_if #(
  parameter int WIDTH = 31
);
  logic             arm;
  logic             mode;
  logic             disarm;
  logic             ack;
  logic [WIDTH-1:0] result_o;
  logic             valid_o;
  logic             overflow_o;
  logic             busy_o;

  modport master (
    output arm, mode, disarm, ack,
    input  result_o, valid_o, overflow_o, busy_o
  );

  modport slave (
    input  arm, mode, disarm, ack,
    output result_o, valid_o, overflow_o, busy_o
  );
endinterface

// File: rtl/onion_capture.sv
// onion_capture
//   Input-capture block: measures either the period (rise to rise) or the
//   high pulse width (rise to fall) of the asynchronous signal capture_i in
//   clk cycles and holds the result behind a valid/ack handshake.
//
//   Parameters:
//     WIDTH        counter and result width in bits
//     SYNC_STAGES  synchroniser depth on capture_i (minimum 2)
//   Ports:
//     clk          reference clock
//     reset        asynchronous, active-low reset
//     capture_i    asynchronous signal under measurement
//     bus          onion_capture_if slave: arm/mode/disarm/ack in,
//                  result_o/valid_o/overflow_o/busy_o out
//
//   Build option:
//     ONION_CAPTURE_GLITCH_FILTER_EN  when defined, a 3-cycle stability
//     filter sits between the synchroniser and the edge detector, so pulses
//     of 1-2 cycles are ignored. Both edges see the same extra lag, so clean
//     inputs measure the same with or without it.
module onion_capture #(
  parameter int WIDTH       = 31,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             capture_i,
  onion_capture_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_START,
    MEASURE,
    DONE
  } state_t;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   level;
  logic                   hist_q;
  logic                   rise;
  logic                   fall;
  logic                   end_edge;
  logic                   mode_q;
  logic [WIDTH-1:0]       counter;
  logic [WIDTH-1:0]       result_q;
  logic                   valid_q;
  logic                   overflow_q;
  logic                   busy_q;

  // Synchroniser chain; the last stage is the clean version of capture_i.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], capture_i};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef ONION_CAPTURE_GLITCH_FILTER_EN
  // Two extra delayed copies of the synchronised level. The filtered level
  // only moves once the current and both previous samples agree, i.e. the
  // input has been stable for 3 cycles; otherwise it keeps its last value
  // (hist_q). Evaluating this combinationally keeps the added lag at 2.
  logic [1:0] stab_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stab_q <= '0;
    end else begin
      stab_q <= {stab_q[0], sync};
    end
  end

  always_comb begin
    level = hist_q;
    if (sync && stab_q[0] && stab_q[1]) begin
      level = 1'b1;
    end else if (!sync && !stab_q[0] && !stab_q[1]) begin
      level = 1'b0;
    end
  end
`else
  assign level = sync;
`endif

  // History flop for edge detection on the (optionally filtered) level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= 1'b0;
    end else begin
      hist_q <= level;
    end
  end

  assign rise     = level & ~hist_q;
  assign fall     = ~level & hist_q;
  assign end_edge = mode_q ? fall : rise;

  // Measurement FSM with registered outputs. The counter is loaded with 1 on
  // the start-edge cycle so that an end edge N detect cycles later reports N.
  // Within MEASURE, disarm beats an edge, and an edge beats saturation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      mode_q     <= 1'b0;
      counter    <= '0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.arm) begin
            state  <= WAIT_START;
            mode_q <= bus.mode;
            busy_q <= 1'b1;
          end
        end

        WAIT_START: begin
          if (bus.disarm) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (rise) begin
            state   <= MEASURE;
            counter <= {{(WIDTH-1){1'b0}}, 1'b1};
          end
        end

        MEASURE: begin
          if (bus.disarm) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            counter <= '0;
          end else if (end_edge) begin
            state      <= DONE;
            result_q   <= counter;
            valid_q    <= 1'b1;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
          end else if (counter == ALL_ONES) begin
            state      <= DONE;
            result_q   <= ALL_ONES;
            valid_q    <= 1'b1;
            overflow_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            counter <= counter + 1'b1;
          end
        end

        DONE: begin
          // The held result is only released by ack; arm alone is ignored.
          if (bus.ack) begin
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            if (bus.arm) begin
              state  <= WAIT_START;
              mode_q <= bus.mode;
              busy_q <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.result_o   = result_q;
  assign bus.valid_o    = valid_q;
  assign bus.overflow_o = overflow_q;
  assign bus.busy_o     = busy_q;

endmodule

// File: tb/tb_onion_capture.sv
// tb_onion_capture
//   Directed self-checking bench for onion_capture. A WIDTH=31 instance
//   covers period, pulse-width, handshake, disarm, reset and glitch cases;
//   a WIDTH=8 instance covers counter saturation.
//   Honours ONION_CAPTURE_GLITCH_FILTER_EN for the expected values.
module tb_onion_capture;

`ifdef ONION_CAPTURE_GLITCH_FILTER_EN
  localparam int FLT_LAG   = 2;
  localparam int GLITCH_RES = 10;
`else
  localparam int FLT_LAG   = 0;
  localparam int GLITCH_RES = 1;
`endif

  logic clk;
  logic reset;
  logic capture_i;
  logic capture8;

  int vectors;
  int miscompares;
  int waited;

  onion_capture_if #(.WIDTH(31)) bus ();
  onion_capture_if #(.WIDTH(8))  bus8 ();

  onion_capture #(.WIDTH(31), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .capture_i (capture_i),
    .bus       (bus)
  );

  onion_capture #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
    .clk       (clk),
    .reset     (reset),
    .capture_i (capture8),
    .bus       (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n clock cycles, landing 1 time unit after the rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle pulse of the control inputs on the WIDTH=31 instance.
  task automatic applyStimulus(input logic arm, input logic mode,
                               input logic ack, input logic disarm);
    bus.arm    = arm;
    bus.mode   = mode;
    bus.ack    = ack;
    bus.disarm = disarm;
    tick(1);
    bus.arm    = 1'b0;
    bus.ack    = 1'b0;
    bus.disarm = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Tick until valid_o of the selected instance is high, up to max cycles.
  task automatic waitValid(input bit sel8, input int max, output int n);
    n = 0;
    while (((sel8 ? bus8.valid_o : bus.valid_o) !== 1'b1) && n < max) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    capture_i   = 1'b0;
    capture8    = 1'b0;
    bus.arm     = 1'b0;
    bus.mode    = 1'b0;
    bus.ack     = 1'b0;
    bus.disarm  = 1'b0;
    bus8.arm    = 1'b0;
    bus8.mode   = 1'b0;
    bus8.ack    = 1'b0;
    bus8.disarm = 1'b0;

    $display("[TB] reset state");
    tick(3);
    checkOutput("rst_result", {1'b0, bus.result_o}, 32'd0);
    checkOutput("rst_valid", {31'd0, bus.valid_o}, 32'd0);
    checkOutput("rst_overflow", {31'd0, bus.overflow_o}, 32'd0);
    checkOutput("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    reset = 1'b1;
    tick(2);

    $display("[TB] mode 0, period 100");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("p100_busy_wait", {31'd0, bus.busy_o}, 32'd1);
    capture_i = 1'b1;
    tick(50);
    checkOutput("p100_busy_meas", {31'd0, bus.busy_o}, 32'd1);
    checkOutput("p100_novalid", {31'd0, bus.valid_o}, 32'd0);
    capture_i = 1'b0;
    tick(50);
    capture_i = 1'b1;
    waitValid(1'b0, 20, waited);
    checkOutput("p100_valid", {31'd0, bus.valid_o}, 32'd1);
    checkOutput("p100_latency", waited, 3 + FLT_LAG);
    checkOutput("p100_result", {1'b0, bus.result_o}, 32'd100);
    checkOutput("p100_overflow", {31'd0, bus.overflow_o}, 32'd0);
    checkOutput("p100_busy_done", {31'd0, bus.busy_o}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("p100_ack_valid", {31'd0, bus.valid_o}, 32'd0);
    checkOutput("p100_ack_busy", {31'd0, bus.busy_o}, 32'd0);

    $display("[TB] mode 1, 37-cycle pulse");
    capture_i = 1'b0;
    tick(5);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("w37_busy_wait", {31'd0, bus.busy_o}, 32'd1);
    capture_i = 1'b1;
    tick(37);
    checkOutput("w37_busy_meas", {31'd0, bus.busy_o}, 32'd1);
    capture_i = 1'b0;
    waitValid(1'b0, 20, waited);
    checkOutput("w37_valid", {31'd0, bus.valid_o}, 32'd1);
    checkOutput("w37_result", {1'b0, bus.result_o}, 32'd37);
    checkOutput("w37_busy_done", {31'd0, bus.busy_o}, 32'd0);

    $display("[TB] arm without ack, then ack+arm back to back");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("noack_valid", {31'd0, bus.valid_o}, 32'd1);
    checkOutput("noack_result", {1'b0, bus.result_o}, 32'd37);
    checkOutput("noack_busy", {31'd0, bus.busy_o}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("b2b_valid", {31'd0, bus.valid_o}, 32'd0);
    checkOutput("b2b_busy", {31'd0, bus.busy_o}, 32'd1);
    tick(3);
    capture_i = 1'b1;
    tick(10);
    capture_i = 1'b0;
    tick(10);
    capture_i = 1'b1;
    waitValid(1'b0, 20, waited);
    checkOutput("b2b_result", {1'b0, bus.result_o}, 32'd20);
    checkOutput("b2b_overflow", {31'd0, bus.overflow_o}, 32'd0);
    capture_i = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("b2b_ack_valid", {31'd0, bus.valid_o}, 32'd0);
    tick(5);

    $display("[TB] disarm mid-measurement");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    capture_i = 1'b1;
    tick(8);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("disarm_busy", {31'd0, bus.busy_o}, 32'd0);
    capture_i = 1'b0;
    tick(10);
    checkOutput("disarm_valid", {31'd0, bus.valid_o}, 32'd0);

    $display("[TB] reset mid-measurement");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    capture_i = 1'b1;
    tick(10);
    checkOutput("mrst_busy_pre", {31'd0, bus.busy_o}, 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("mrst_busy", {31'd0, bus.busy_o}, 32'd0);
    checkOutput("mrst_valid", {31'd0, bus.valid_o}, 32'd0);
    checkOutput("mrst_result", {1'b0, bus.result_o}, 32'd0);
    tick(2);
    reset = 1'b1;
    tick(5);
    capture_i = 1'b0;
    tick(10);
    checkOutput("mrst_after_valid", {31'd0, bus.valid_o}, 32'd0);
    checkOutput("mrst_after_busy", {31'd0, bus.busy_o}, 32'd0);
    checkOutput("mrst_after_ovf", {31'd0, bus.overflow_o}, 32'd0);

    $display("[TB] glitch: 1-cycle pulse then 10-cycle pulse");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    capture_i = 1'b1;
    tick(1);
    capture_i = 1'b0;
    tick(5);
    capture_i = 1'b1;
    tick(10);
    capture_i = 1'b0;
    waitValid(1'b0, 20, waited);
    checkOutput("glitch_valid", {31'd0, bus.valid_o}, 32'd1);
    checkOutput("glitch_result", {1'b0, bus.result_o}, GLITCH_RES);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    tick(5);

    $display("[TB] WIDTH=8 saturation");
    bus8.arm  = 1'b1;
    bus8.mode = 1'b1;
    tick(1);
    bus8.arm  = 1'b0;
    capture8  = 1'b1;
    waitValid(1'b1, 400, waited);
    checkOutput("sat_valid", {31'd0, bus8.valid_o}, 32'd1);
    checkOutput("sat_latency", waited, 258 + FLT_LAG);
    checkOutput("sat_result", {24'd0, bus8.result_o}, 32'hFF);
    checkOutput("sat_overflow", {31'd0, bus8.overflow_o}, 32'd1);
    checkOutput("sat_busy", {31'd0, bus8.busy_o}, 32'd0);
    bus8.ack = 1'b1;
    tick(1);
    bus8.ack = 1'b0;
    checkOutput("sat_ack_valid", {31'd0, bus8.valid_o}, 32'd0);
    checkOutput("sat_ack_overflow", {31'd0, bus8.overflow_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
